// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller owning HI/LO; results land N cycles after acceptance.
// No input handshake: md_stall holds MD-class instructions in D while an operation is in flight.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_is_md,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q, lo_q, pend_hi, pend_lo;
    logic             is_mul, is_div;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      res_hi, res_lo;

    always_comb begin
        is_mul   = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU);
        is_div   = (E_md_op == MD_DIV)  || (E_md_op == MD_DIVU);
        start    = (state == STATE_IDLE) && (is_mul || is_div);
        busy     = (state == STATE_BUSY);
        md_stall = D_is_md && (start || busy);
        HI       = hi_q;
        LO       = lo_q;
        case (E_md_op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

    always_comb begin
        prod_s = $signed({{32{E_rs_val[31]}}, E_rs_val}) * $signed({{32{E_rt_val[31]}}, E_rt_val});
        prod_u = {32'd0, E_rs_val} * {32'd0, E_rt_val};
        // Divide by zero re-latches the current HI/LO so completion leaves them unchanged.
        res_hi = hi_q;
        res_lo = lo_q;
        case (E_md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (E_rt_val == 32'd0) begin
                    res_hi = hi_q;
                end else if (E_rs_val == 32'h8000_0000 && E_rt_val == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(E_rs_val) / $signed(E_rt_val);
                    res_hi = $signed(E_rs_val) % $signed(E_rt_val);
                end
            end
            MD_DIVU: begin
                if (E_rt_val != 32'd0) begin
                    res_lo = E_rs_val / E_rt_val;
                    res_hi = E_rs_val % E_rt_val;
                end
            end
            default: res_hi = hi_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= STATE_IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (state == STATE_IDLE) begin
            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                state   <= STATE_BUSY;
            end else if (E_md_op == MD_MTHI) begin
                hi_q <= E_rs_val;
            end else if (E_md_op == MD_MTLO) begin
                lo_q <= E_rs_val;
            end
        end else begin
            // Ops arriving in BUSY are ignored; only the counter advances.
            if (cnt == CNT_W'(1)) begin
                hi_q  <= pend_hi;
                lo_q  <= pend_lo;
                cnt   <= '0;
                state <= STATE_IDLE;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table plus injection and reset-abort sequences.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs_val, E_rt_val;
    logic        D_is_md;
    logic        start, busy, md_stall;
    logic [31:0] HI, LO, md_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_rs_val(E_rs_val),
        .E_rt_val(E_rt_val), .D_is_md(D_is_md), .start(start), .busy(busy),
        .md_stall(md_stall), .HI(HI), .LO(LO), .md_out(md_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        d;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic d, input logic [3:0] inj,
                           input int n, input logic [31:0] hi, input logic [31:0] lo);
        int  k;
        logic exp_start;
        exp_start = (op >= 4'd1) && (op <= 4'd4);
        E_md_op = op; E_rs_val = rs; E_rt_val = rt; D_is_md = d;
        @(negedge clk);
        chk({tag, "_start"}, 32'(start), 32'(exp_start));
        chk({tag, "_stall_T"}, 32'(md_stall), 32'(d & exp_start));
        @(posedge clk); #1;
        E_md_op = 4'd0; E_rs_val = $urandom; E_rt_val = $urandom;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
            k++;
            chk({tag, "_stall_busy"}, 32'(md_stall), 32'(d));
            chk({tag, "_start_busy"}, 32'(start), 32'd0);
            @(posedge clk); #1;
            E_md_op = (k == 2) ? inj : 4'd0;
            E_rs_val = $urandom; E_rt_val = $urandom;
        end
        chk({tag, "_busy_cycles"}, 32'(k), 32'(n));
        chk({tag, "_stall_done"}, 32'(md_stall), 32'd0);
        chk({tag, "_hi"}, HI, hi);
        chk({tag, "_lo"}, LO, lo);
        @(posedge clk); #1;
        E_md_op = 4'd7;
        @(negedge clk);
        chk({tag, "_mfhi"}, md_out, hi);
        chk({tag, "_mfhi_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        E_md_op = 4'd8;
        @(negedge clk);
        chk({tag, "_mflo"}, md_out, lo);
        @(posedge clk); #1;
        E_md_op = 4'd0; D_is_md = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFF_FFFD, 32'd5,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{4'd4, 32'd7,         32'd2,         1'b0, 10, 32'd1,         32'd3};
        vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0,         32'h8000_0000};
        vecs[4]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{4'd4, 32'hFFFF_FFFF, 32'd10,        1'b0, 10, 32'd5,         32'h1999_9999};
        vecs[6]  = '{4'd1, 32'd7,         32'hFFFF_FFFE, 1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[7]  = '{4'd5, 32'hDEAD_BEEF, 32'd0,         1'b1, 0,  32'hDEAD_BEEF, 32'hFFFF_FFF2};
        vecs[8]  = '{4'd6, 32'h0000_1234, 32'd0,         1'b0, 0,  32'hDEAD_BEEF, 32'h0000_1234};
        vecs[9]  = '{4'd12, 32'd5,        32'd3,         1'b1, 0,  32'hDEAD_BEEF, 32'h0000_1234};
        vecs[10] = '{4'd5, 32'h11,        32'd0,         1'b0, 0,  32'h11,        32'h1234};
        vecs[11] = '{4'd6, 32'h22,        32'd0,         1'b0, 0,  32'h11,        32'h22};
        vecs[12] = '{4'd4, 32'd9,         32'd0,         1'b1, 10, 32'h11,        32'h22};

        reset = 1'b0; E_md_op = 4'd0; E_rs_val = 32'd0; E_rt_val = 32'd0; D_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].d,
                    4'd0, vecs[i].n, vecs[i].hi, vecs[i].lo);

        // Ops injected mid-operation must not disturb HI/LO or the busy period.
        run_vec("div0_inj_mthi", 4'd3, 32'd5, 32'd0, 1'b1, 4'd5, 10, 32'h11, 32'h22);
        run_vec("mult_inj_mult", 4'd1, 32'd3, 32'd4, 1'b0, 4'd1, 5, 32'd0, 32'd12);

        // Reset during cycle T+3 of a divide aborts it.
        E_md_op = 4'd3; E_rs_val = 32'd100; E_rt_val = 32'd7;
        @(posedge clk); #1;
        E_md_op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_hi_later", HI, 32'd0);
        chk("abort_lo_later", LO, 32'd0);
        chk("abort_busy_later", 32'(busy), 32'd0);

        run_vec("post_rst_multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd0, 5, 32'd1, 32'hFFFF_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and owns the HI/LO registers.
- Sequences the multi-cycle operation with a busy counter.
- Drives md_stall, which the hazard unit ORs into its D-stage stall so no MD-class instruction leaves D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (1..15).
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- E_md_op  input  4  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..15 treated as none.
- E_rs_val  input  32  forwarded rs value in E.
- E_rt_val  input  32  forwarded rt value in E.
- D_is_md  input  1  D-stage instruction is any of opcodes 1..8.
- start  output  1  combinational; 1 when a mult/multu/div/divu is accepted this cycle.
- busy  output  1  registered; operation in flight.
- md_stall  output  1  combinational stall request to the hazard unit.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- md_out  output  32  E-stage read value: HI for mfhi, LO for mflo, 0 otherwise.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, counter=0, busy=0, HI=0, LO=0, pending results=0.
  - Reset dominates any op in the same cycle.
  - Reset mid-operation aborts the operation; the result is discarded.
- States: IDLE, BUSY.
- IDLE, E_md_op in 1..4:
  - start=1.
  - At the edge: latch the result into pending_hi/pending_lo, load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), go to BUSY.
- BUSY:
  - busy=1, start=0.
  - Counter decrements each edge.
  - On the edge where counter==1: HI/LO <= pending values, counter<=0, go to IDLE.
- Timing: op accepted in cycle T gives busy=1 in cycles T+1..T+N. New HI/LO are visible from T+N+1. busy=0 in T+N+1.
- mthi/mtlo in IDLE: HI (resp. LO) <= E_rs_val at the edge. No busy.
- mfhi/mflo: md_out = current HI/LO, combinational. Valid only in IDLE, which the stall rule guarantees.
- Any E_md_op arriving while busy=1 is ignored. HI, LO and counter are unaffected. This is illegal by construction.
- md_stall = D_is_md & (start | busy). It is asserted in cycles T..T+N and deasserted in T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64. {HI,LO} = product.
  - multu: unsigned 32x32 -> 64. {HI,LO} = product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (E_rt_val==0, op 3 or 4): the operation runs the full DIV_CYCLES busy period, then HI/LO keep their prior values.
- The result is computed at acceptance from the E-stage operands. Later changes to E_rs_val/E_rt_val during BUSY have no effect.

Test Plan:
- Reset, then mult rs=0xFFFFFFFD (-3), rt=5 at cycle T:
  - start=1 in T; busy=1 for T+1..T+5.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1 from T+6.
- divu rs=7, rt=2:
  - busy for exactly 10 cycles.
  - Then LO=3, HI=1.
  - div rs=0xFFFFFFF9 (-7), rt=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Mult accepted with D_is_md=1 held (mflo in D):
  - md_stall=1 in T..T+5, 0 in T+6.
  - mflo in E then gives md_out=new LO.
  - With D_is_md=0, md_stall stays 0 throughout.
- Divide by zero with HI=0x11, LO=0x22 preset:
  - busy=1 for 10 cycles.
  - HI=0x11, LO=0x22 unchanged afterwards.
  - An op injected mid-BUSY is ignored.
- mthi rs=0xDEADBEEF, then mfhi: md_out=0xDEADBEEF with no busy. mtlo 0x1234, then mflo: md_out=0x1234.
- Reset asserted at T+3 of a div:
  - busy=0, HI=LO=0 on the next cycle.
  - A subsequent multu 0xFFFFFFFF*2 gives HI=1, LO=0xFFFFFFFE.
